// File: rtl/master_pin_change_ctrl_pkg.sv
// Shared types and PIN helpers for the master-PIN change sequencer.
// Blank keypad digits count as zero wherever a PIN is compared or staged.
package master_pin_change_ctrl_pkg;

    typedef struct packed {
        logic       status;
        logic [3:0] digit1;
        logic [3:0] digit2;
        logic [3:0] digit3;
        logic [3:0] digit4;
    } pinPac_t;

    localparam logic [3:0] BLANK_DIGIT = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_AUTH      = 3'd1,
        ST_ENTER_NEW = 3'd2,
        ST_CONFIRM   = 3'd3,
        ST_COMMIT    = 3'd4,
        ST_RELEASE   = 3'd5,
        ST_LOCKOUT   = 3'd6
    } state_t;

    function automatic logic [3:0] normalise(input logic [3:0] d);
        return (d == BLANK_DIGIT) ? 4'd0 : d;
    endfunction

    function automatic pinPac_t normalise_pin(input pinPac_t p);
        pinPac_t r;
        r.status = p.status;
        r.digit1 = normalise(p.digit1);
        r.digit2 = normalise(p.digit2);
        r.digit3 = normalise(p.digit3);
        r.digit4 = normalise(p.digit4);
        return r;
    endfunction

    function automatic logic pin_equal(input pinPac_t a, input pinPac_t b);
        pinPac_t na;
        pinPac_t nb;
        na = normalise_pin(a);
        nb = normalise_pin(b);
        return {na.digit1, na.digit2, na.digit3, na.digit4} ==
               {nb.digit1, nb.digit2, nb.digit3, nb.digit4};
    endfunction

    function automatic logic pin_is_zero(input pinPac_t p);
        pinPac_t n;
        n = normalise_pin(p);
        return {n.digit1, n.digit2, n.digit3, n.digit4} == 16'h0000;
    endfunction

endpackage

// File: rtl/master_pin_change_ctrl_pin_timer.sv
// Loadable up-counter with clear, enable and terminal-count compare.
// Holds at the terminal value so it can never wrap.
module pin_timer #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic [W-1:0] i_terminal,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_enable && (r_count != i_terminal)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == i_terminal);

endmodule

// File: rtl/master_pin_change_ctrl.sv
// Master-PIN change sequencer: authenticate, enter, confirm, then commit
// through the updater's enable/done handshake, with timeout and lockout.
module master_pin_change_ctrl
    import master_pin_change_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       setup_req,
    input  pinPac_t    pin_in,
    input  pinPac_t    master_pin,
    input  logic       upd_done,
    output logic       upd_enable,
    output pinPac_t    upd_pin,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic       locked,
    output logic [2:0] state_o
);

    localparam int TMAX = (TIMEOUT_CYCLES > LOCKOUT_CYCLES) ? TIMEOUT_CYCLES : LOCKOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int AW   = $clog2(MAX_ATTEMPTS + 1);

    // Terminal counts are one below the limit so the state occupies exactly N cycles.
    localparam logic [TW-1:0] TIMEOUT_TC = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_TC = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [AW-1:0] ATT_LIMIT  = AW'(MAX_ATTEMPTS);
    localparam logic [AW-1:0] ATT_LAST   = AW'(MAX_ATTEMPTS - 1);

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_attempts;
    logic [AW-1:0] w_attempts;
    pinPac_t       r_staged;
    pinPac_t       w_staged;
    pinPac_t       w_commit_pin;
    logic          r_via_done;
    logic          w_via_done;
    logic          w_fail;
    logic          w_done;

    logic          w_entry;
    logic          w_tc;
    logic          w_timer_clear;
    logic          w_timer_en;
    logic [TW-1:0] w_terminal;

    logic          r_upd_enable;
    pinPac_t       r_upd_pin;
    logic          r_busy;
    logic          r_done;
    logic          r_fail;
    logic          r_locked;

    assign w_entry       = pin_in.status && (r_state != ST_LOCKOUT);
    assign w_timer_en    = (r_state != ST_IDLE) && (r_state != ST_RELEASE);
    assign w_terminal    = (r_state == ST_LOCKOUT) ? LOCKOUT_TC : TIMEOUT_TC;
    assign w_timer_clear = (w_next != r_state) || w_entry;

    pin_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_timer_clear),
        .i_enable   (w_timer_en),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_terminal (w_terminal),
        .o_tc       (w_tc)
    );

    always_comb begin
        w_next     = r_state;
        w_attempts = r_attempts;
        w_staged   = r_staged;
        w_via_done = r_via_done;
        w_fail     = 1'b0;
        w_done     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (setup_req) w_next = ST_AUTH;
            end
            ST_AUTH: begin
                if (pin_in.status) begin
                    if (pin_equal(pin_in, master_pin)) begin
                        w_next     = ST_ENTER_NEW;
                        w_attempts = '0;
                    end else begin
                        w_fail = 1'b1;
                        if (r_attempts >= ATT_LAST) begin
                            w_attempts = ATT_LIMIT;
                            w_next     = ST_LOCKOUT;
                        end else begin
                            w_attempts = r_attempts + 1'b1;
                        end
                    end
                end else if (w_tc) begin
                    w_fail = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_ENTER_NEW: begin
                if (pin_in.status) begin
                    if (pin_is_zero(pin_in)) begin
                        w_fail = 1'b1;
                    end else begin
                        w_staged        = normalise_pin(pin_in);
                        w_staged.status = 1'b0;
                        w_next          = ST_CONFIRM;
                    end
                end else if (w_tc) begin
                    w_fail = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_CONFIRM: begin
                if (pin_in.status) begin
                    if (pin_equal(pin_in, r_staged)) begin
                        w_next = ST_COMMIT;
                    end else begin
                        w_fail   = 1'b1;
                        w_staged = '0;
                        w_next   = ST_ENTER_NEW;
                    end
                end else if (w_tc) begin
                    w_fail = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (upd_done) begin
                    w_via_done = 1'b1;
                    w_next     = ST_RELEASE;
                end else if (w_tc && !pin_in.status) begin
                    w_fail     = 1'b1;
                    w_via_done = 1'b0;
                    w_next     = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_done = r_via_done;
                w_next = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (w_tc) begin
                    w_attempts = '0;
                    w_next     = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase

        // Nothing staged survives a return to IDLE, whatever the route.
        if (w_next == ST_IDLE) begin
            w_staged   = '0;
            w_via_done = 1'b0;
        end

        w_commit_pin        = w_staged;
        w_commit_pin.status = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_attempts   <= '0;
            r_staged     <= '0;
            r_via_done   <= 1'b0;
            r_upd_enable <= 1'b0;
            r_upd_pin    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_attempts   <= w_attempts;
            r_staged     <= w_staged;
            r_via_done   <= w_via_done;
            r_upd_enable <= (w_next == ST_COMMIT);
            r_upd_pin    <= (w_next == ST_COMMIT) ? w_commit_pin : '0;
            r_busy       <= (w_next != ST_IDLE);
            r_done       <= w_done;
            r_fail       <= w_fail;
            r_locked     <= (w_next == ST_LOCKOUT);
        end
    end

    assign upd_enable = r_upd_enable;
    assign upd_pin    = r_upd_pin;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fail       = r_fail;
    assign locked     = r_locked;
    assign state_o    = r_state;

endmodule

// File: tb/tb_master_pin_change_ctrl.sv
// Bench for master_pin_change_ctrl: directed PIN sequences, a per-cycle
// reference model of the change flow, and literal expectations at key points.
module tb_master_pin_change_ctrl;
    import master_pin_change_ctrl_pkg::*;

    localparam int T = 20;
    localparam int M = 3;
    localparam int L = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       setup_req;
    logic       upd_done;
    pinPac_t    pin_in;
    pinPac_t    master_pin;
    logic       upd_enable;
    pinPac_t    upd_pin;
    logic       busy;
    logic       done;
    logic       fail;
    logic       locked;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    master_pin_change_ctrl #(
        .TIMEOUT_CYCLES (T),
        .MAX_ATTEMPTS   (M),
        .LOCKOUT_CYCLES (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .setup_req  (setup_req),
        .pin_in     (pin_in),
        .master_pin (master_pin),
        .upd_done   (upd_done),
        .upd_enable (upd_enable),
        .upd_pin    (upd_pin),
        .busy       (busy),
        .done       (done),
        .fail       (fail),
        .locked     (locked),
        .state_o    (state_o)
    );

    function automatic pinPac_t mk(input int a, input int b, input int c, input int d);
        pinPac_t p;
        p.status = 1'b1;
        p.digit1 = 4'(a);
        p.digit2 = 4'(b);
        p.digit3 = 4'(c);
        p.digit4 = 4'(d);
        return p;
    endfunction

    function automatic int nd(input logic [3:0] d);
        return (d == 4'd14) ? 0 : int'(d);
    endfunction

    // PIN value as a number: the four normalised digits in base 16.
    function automatic int code_of(input pinPac_t p);
        return nd(p.digit1) * 4096 + nd(p.digit2) * 256 + nd(p.digit3) * 16 + nd(p.digit4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase, attempt count, idle-cycle count and staged PIN value.
    state_t m_ph = ST_IDLE;
    int     m_att = 0;
    int     m_idle = 0;
    int     m_staged = 0;
    bit     m_via = 1'b0;
    logic   e_fail = 1'b0;
    logic   e_done = 1'b0;

    task automatic model_step();
        state_t prev;
        bit     entry;
        int     code;
        e_fail = 1'b0;
        e_done = 1'b0;
        if (rst) begin
            m_ph = ST_IDLE; m_att = 0; m_idle = 0; m_staged = 0; m_via = 1'b0;
            return;
        end
        prev  = m_ph;
        entry = pin_in.status && (m_ph != ST_LOCKOUT);
        code  = code_of(pin_in);
        case (m_ph)
            ST_IDLE: if (setup_req) m_ph = ST_AUTH;
            ST_AUTH: begin
                if (entry) begin
                    if (code == code_of(master_pin)) begin
                        m_ph = ST_ENTER_NEW; m_att = 0;
                    end else begin
                        e_fail = 1'b1; m_att++;
                        if (m_att >= M) m_ph = ST_LOCKOUT;
                    end
                end else if (m_idle + 1 >= T) begin
                    e_fail = 1'b1; m_ph = ST_IDLE;
                end
            end
            ST_ENTER_NEW: begin
                if (entry) begin
                    if (code == 0) e_fail = 1'b1;
                    else begin m_staged = code; m_ph = ST_CONFIRM; end
                end else if (m_idle + 1 >= T) begin
                    e_fail = 1'b1; m_ph = ST_IDLE;
                end
            end
            ST_CONFIRM: begin
                if (entry) begin
                    if (code == m_staged) m_ph = ST_COMMIT;
                    else begin e_fail = 1'b1; m_staged = 0; m_ph = ST_ENTER_NEW; end
                end else if (m_idle + 1 >= T) begin
                    e_fail = 1'b1; m_ph = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (upd_done) begin
                    m_via = 1'b1; m_ph = ST_RELEASE;
                end else if (!entry && m_idle + 1 >= T) begin
                    e_fail = 1'b1; m_via = 1'b0; m_ph = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                e_done = m_via; m_via = 1'b0; m_ph = ST_IDLE;
            end
            ST_LOCKOUT: if (m_idle + 1 >= L) begin m_att = 0; m_ph = ST_IDLE; end
            default: m_ph = ST_IDLE;
        endcase
        if (m_ph == ST_IDLE) m_staged = 0;
        if (m_ph != prev || entry) m_idle = 0;
        else if (prev != ST_IDLE && prev != ST_RELEASE) m_idle++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        logic [16:0] ep;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                ep = (m_ph == ST_COMMIT) ? {1'b1, 16'(m_staged)} : 17'h0;
                chk("m_state",  32'(state_o),    32'(m_ph));
                chk("m_busy",   32'(busy),       32'(m_ph != ST_IDLE));
                chk("m_locked", 32'(locked),     32'(m_ph == ST_LOCKOUT));
                chk("m_en",     32'(upd_enable), 32'(m_ph == ST_COMMIT));
                chk("m_pin",    32'(upd_pin),    32'(ep));
                chk("m_fail",   32'(fail),       32'(e_fail));
                chk("m_done",   32'(done),       32'(e_done));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic setup();
        setup_req = 1'b1;
        @(negedge clk);
        setup_req = 1'b0;
    endtask

    task automatic enter(input pinPac_t p);
        pin_in = p;
        @(negedge clk);
        pin_in.status = 1'b0;
    endtask

    task automatic handshake();
        upd_done = 1'b1;
        @(negedge clk);
        upd_done = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        rst = 1'b1; setup_req = 1'b0; upd_done = 1'b0;
        pin_in = '0; master_pin = mk(1, 2, 3, 4);
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'(upd_enable), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full successful change 1234 -> 5678, updater answers after two cycles.
        setup();
        enter(mk(1, 2, 3, 4));
        enter(mk(5, 6, 7, 8));
        enter(mk(5, 6, 7, 8));
        chk("s1_state", 32'(state_o), 32'(ST_COMMIT));
        chk("s1_pin", 32'(upd_pin), 32'h15678);
        repeat (2) @(negedge clk);
        chk("s1_en_hold", 32'(upd_enable), 32'd1);
        upd_done = 1'b1;
        @(negedge clk);
        upd_done = 1'b0;
        chk("s1_rel_en", 32'(upd_enable), 32'd0);
        chk("s1_rel_state", 32'(state_o), 32'(ST_RELEASE));
        @(negedge clk);
        chk("s1_done", 32'(done), 32'd1);
        chk("s1_idle", 32'(state_o), 32'(ST_IDLE));

        // Three wrong PINs -> lockout for exactly L cycles.
        setup();
        enter(mk(9, 9, 9, 9));
        chk("s2_fail1", 32'(fail), 32'd1);
        enter(mk(9, 9, 9, 9));
        enter(mk(9, 9, 9, 9));
        chk("s2_lock_state", 32'(state_o), 32'(ST_LOCKOUT));
        cnt = 0;
        while (locked === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("s2_lock_len", 32'(cnt), 32'(L));
        chk("s2_idle", 32'(state_o), 32'(ST_IDLE));
        setup();
        enter(mk(9, 9, 9, 9));
        chk("s2_att_cleared", 32'(state_o), 32'(ST_AUTH));

        // Confirm mismatch, then a good 4321 change; setup_req ignored while busy.
        enter(mk(1, 2, 3, 4));
        setup();
        chk("s3_setup_ignored", 32'(state_o), 32'(ST_ENTER_NEW));
        enter(mk(5, 6, 7, 8));
        enter(mk(5, 6, 7, 9));
        chk("s3_mismatch", 32'(fail), 32'd1);
        chk("s3_back", 32'(state_o), 32'(ST_ENTER_NEW));
        enter(mk(4, 3, 2, 1));
        enter(mk(4, 3, 2, 1));
        chk("s3_pin", 32'(upd_pin), 32'h14321);
        handshake();
        chk("s3_done", 32'(done), 32'd1);

        // Blank digits normalise to zero; an all-blank new PIN is refused.
        setup();
        enter(mk(1, 2, 3, 4));
        enter(mk(1, 2, 14, 14));
        chk("s4_confirm", 32'(state_o), 32'(ST_CONFIRM));
        enter(mk(1, 2, 0, 0));
        chk("s4_pin", 32'(upd_pin), 32'h11200);
        handshake();
        setup();
        enter(mk(1, 2, 3, 4));
        enter(mk(14, 14, 14, 14));
        chk("s4_zero_fail", 32'(fail), 32'd1);
        chk("s4_stay", 32'(state_o), 32'(ST_ENTER_NEW));

        // Confirm timeout: fail appears exactly T cycles after entering CONFIRM.
        enter(mk(5, 5, 5, 5));
        cnt = 0;
        while (fail !== 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("s5_timeout_at", 32'(cnt), 32'(T));
        chk("s5_idle", 32'(state_o), 32'(ST_IDLE));

        // Entry in the expiry cycle wins, then the updater never answers.
        setup();
        enter(mk(1, 2, 3, 4));
        enter(mk(5, 5, 5, 5));
        repeat (T - 1) @(negedge clk);
        enter(mk(5, 5, 5, 5));
        chk("s5_late_entry", 32'(state_o), 32'(ST_COMMIT));
        chk("s5_no_fail", 32'(fail), 32'd0);
        cnt = 0;
        while (state_o == 3'(ST_COMMIT) && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        chk("s5_commit_len", 32'(cnt), 32'(T));
        chk("s5_commit_fail", 32'(fail), 32'd1);
        @(negedge clk);
        chk("s5_no_done", 32'(done), 32'd0);

        // Reset while committing.
        setup();
        enter(mk(1, 2, 3, 4));
        enter(mk(5, 5, 5, 5));
        enter(mk(5, 5, 5, 5));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("s6_en", 32'(upd_enable), 32'd0);
        chk("s6_busy", 32'(busy), 32'd0);
        chk("s6_state", 32'(state_o), 32'(ST_IDLE));
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
